// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the forwarding select codes, the load ResultSrc code, the hazard FSM
// state encoding, the shadow-pipeline slot layouts and a small register-match
// helper that both the hazard logic and the forward unit use.
package pipe_hazard_ctrl_pkg;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register file
    FWD_WB  = 2'b01,  // WB-stage result
    FWD_MEM = 2'b10   // MEM-stage result
  } fwd_sel_e;

  // ID ResultSrc value that marks a load
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } hz_state_e;

  // EX keeps the source indices for forwarding and is_load for load-use.
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
    logic       is_mem;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_slot_t;

  // Later stages carry only the fields still consulted downstream.
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       is_mem;
  } mem_slot_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
  } wb_slot_t;

  // True when a stage that writes rd produces the value read as rs; x0 never matches.
  function automatic logic writes_reg(input logic we, input logic [4:0] rd,
                                      input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_forward_unit.sv
// forward_unit: combinational operand-forwarding select for one EX operand.
// Ports:
//   rs_i              EX source register index
//   mem_rd_i/mem_we_i MEM-stage destination and write enable
//   wb_rd_i/wb_we_i   WB-stage destination and write enable
//   sel_o             operand select (MEM has priority over WB)
module forward_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_we_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_we_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (writes_reg(mem_we_i, mem_rd_i, rs_i)) begin
      sel_o = FWD_MEM;
    end else if (writes_reg(wb_we_i, wb_rd_i, rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and memory-wait control for a 5-stage
// pipeline. A shadow copy of the EX/MEM/WB stage registers is kept here and
// advances in lock-step with the datapath.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_*                        decoded ID-stage instruction fields
//   ex_PCSrc                    taken branch/jump resolved in EX
//   mem_ready                   data memory completes the MEM access this cycle
//   stall_IF/ID/EX/MEM          hold the corresponding stage register
//   flush_ID, flush_EX          load a bubble into ID / EX
//   bubble_WB                   WB register loads a bubble
//   ForwardAE, ForwardBE        EX operand selects
//   mem_timeout                 sticky memory timeout flag
//   stall_cycles, flush_count   saturating performance counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_RegWrite,
  input  logic             id_MemWrite,
  input  logic [1:0]       id_ResultSrc,
  input  logic             ex_PCSrc,
  input  logic             mem_ready,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             stall_MEM,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic             bubble_WB,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Wait counter only has to reach TIMEOUT-1.
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  hz_state_e         state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_q;
  ex_slot_t          ex_q, ex_d, id_slot;
  mem_slot_t         mem_q, mem_d;
  wb_slot_t          wb_q, wb_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

  logic mem_busy, freeze, active, load_use_raw, branch, load_use;

  // freeze: whole front of the pipe holds while MEM waits (or after timeout).
  // active: pipe advances this cycle, so branch and load-use are honoured.
  // In MEM_WAIT the cycle that sees mem_ready is already an advancing cycle,
  // which is also when a branch held in EX during the wait takes effect.
  always_comb begin
    mem_busy = mem_q.is_mem & ~mem_ready;
    freeze   = 1'b0;
    active   = 1'b0;
    case (state_q)
      ST_RUN: begin
        freeze = mem_busy;
        active = ~mem_busy;
      end
      ST_MEM_WAIT: begin
        freeze = ~mem_ready;
        active = mem_ready;
      end
      default: freeze = 1'b1;
    endcase
    if (reset) begin
      freeze = 1'b0;
      active = 1'b0;
    end
  end

  always_comb begin
    load_use_raw = id_valid & ex_q.is_load &
                   ((id_uses_rs1 & writes_reg(1'b1, ex_q.rd, id_rs1)) |
                    (id_uses_rs2 & writes_reg(1'b1, ex_q.rd, id_rs2)));
    branch   = active & ex_PCSrc;
    load_use = active & ~ex_PCSrc & load_use_raw;

    stall_IF  = freeze | load_use;
    stall_ID  = freeze | load_use;
    stall_EX  = freeze;
    stall_MEM = freeze;
    bubble_WB = freeze;
    flush_ID  = branch;
    flush_EX  = branch | load_use;
  end

  always_comb begin
    id_slot = '0;
    if (id_valid) begin
      id_slot.rd        = id_rd;
      id_slot.reg_write = id_RegWrite;
      id_slot.is_load   = (id_ResultSrc == RESULT_LOAD);
      id_slot.is_mem    = id_MemWrite | (id_ResultSrc == RESULT_LOAD);
      id_slot.rs1       = id_rs1;
      id_slot.rs2       = id_rs2;
    end

    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = '0;
    if (!freeze) begin
      ex_d            = flush_EX ? '0 : id_slot;
      mem_d.rd        = ex_q.rd;
      mem_d.reg_write = ex_q.reg_write;
      mem_d.is_mem    = ex_q.is_mem;
      wb_d.rd         = mem_q.rd;
      wb_d.reg_write  = mem_q.reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_busy) begin
            state_q <= ST_MEM_WAIT;
            wait_q  <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state_q <= ST_RUN;
          end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            state_q   <= ST_ERROR;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_ERROR;
          timeout_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_IF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_ID && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

  forward_unit u_fwd_a (
    .rs_i     (ex_q.rs1),
    .mem_rd_i (mem_q.rd),
    .mem_we_i (mem_q.reg_write),
    .wb_rd_i  (wb_q.rd),
    .wb_we_i  (wb_q.reg_write),
    .sel_o    (ForwardAE)
  );

  forward_unit u_fwd_b (
    .rs_i     (ex_q.rs2),
    .mem_rd_i (mem_q.rd),
    .mem_we_i (mem_q.reg_write),
    .wb_rd_i  (wb_q.rd),
    .wb_we_i  (wb_q.reg_write),
    .sel_o    (ForwardBE)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a stimulus process drives one cycle
// at a time and queues the expected outputs from an instruction-level model;
// a monitor on the falling edge pops and compares.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  localparam int unsigned TO   = 4;
  localparam int unsigned CW   = 5;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, id_valid, id_uses_rs1, id_uses_rs2, id_RegWrite, id_MemWrite;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_ResultSrc;
  logic ex_PCSrc, mem_ready;
  logic stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, bubble_WB;
  logic [1:0] ForwardAE, ForwardBE;
  logic mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite),
    .id_ResultSrc(id_ResultSrc), .ex_PCSrc(ex_PCSrc), .mem_ready(mem_ready),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
    .stall_MEM(stall_MEM), .flush_ID(flush_ID), .flush_EX(flush_EX),
    .bubble_WB(bubble_WB), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int rd; int rs1; int rs2; bit u1; bit u2; bit rw; bit mw; logic [1:0] src;
  } instr_t;
  typedef struct {
    logic [1:0] fa; logic [1:0] fb;
    bit sif; bit sid; bit sex; bit smem; bit fid; bit fex; bit bwb; bit tmo;
    int sc; int fc;
  } exp_t;

  exp_t   sbq[$];
  exp_t   mon_e;
  int     n_vec = 0;
  int     n_err = 0;

  // Instruction-level model: one instruction record per stage.
  instr_t m_ex, m_mem, m_wb, EMPTY;
  bit     waiting, errored;
  int     waited, m_sc, m_fc;
  // Feedback to the random driver: a stalled ID re-presents its instruction,
  // and a frozen EX keeps its branch outcome.
  bit     last_sid, last_freeze, prev_pc;
  instr_t prev_id;

  function automatic instr_t mk(bit v, int rd, int rs1, int rs2, bit u1, bit u2,
                                bit rw, bit mw, logic [1:0] src);
    instr_t i;
    i.v = v; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
    i.rw = rw; i.mw = mw; i.src = src;
    return i;
  endfunction

  function automatic bit produces(instr_t i, int rs);
    return i.v && i.rw && i.rd != 0 && i.rd == rs;
  endfunction

  function automatic logic [1:0] fwd_of(int rs);
    if (produces(m_mem, rs)) return 2'b10;
    if (produces(m_wb, rs))  return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit accesses_mem(instr_t i);
    return i.v && (i.mw || i.src == 2'b01);
  endfunction

  task automatic model_clear();
    m_ex = EMPTY; m_mem = EMPTY; m_wb = EMPTY;
    waiting = 0; errored = 0; waited = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic step(input bit rst, input instr_t id, input bit pc, input bit mr);
    exp_t e;
    bit freeze, live, br, lu, haz;
    reset = rst; id_valid = id.v; id_rd = 5'(id.rd); id_rs1 = 5'(id.rs1);
    id_rs2 = 5'(id.rs2); id_uses_rs1 = id.u1; id_uses_rs2 = id.u2;
    id_RegWrite = id.rw; id_MemWrite = id.mw; id_ResultSrc = id.src;
    ex_PCSrc = pc; mem_ready = mr;

    freeze = !rst && (errored || (waiting ? !mr : (accesses_mem(m_mem) && !mr)));
    live   = !rst && !freeze;
    haz    = m_ex.v && m_ex.src == 2'b01 && m_ex.rd != 0 && id.v &&
             ((id.u1 && id.rs1 == m_ex.rd) || (id.u2 && id.rs2 == m_ex.rd));
    br = live && pc;
    lu = live && !pc && haz;

    e.sif = freeze || lu; e.sid = freeze || lu; e.sex = freeze; e.smem = freeze;
    e.bwb = freeze; e.fid = br; e.fex = br || lu; e.tmo = errored;
    e.sc = m_sc; e.fc = m_fc;
    e.fa = fwd_of(m_ex.rs1); e.fb = fwd_of(m_ex.rs2);
    sbq.push_back(e);
    last_sid = e.sid; last_freeze = freeze; prev_id = id; prev_pc = pc;

    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (e.sif && m_sc < CMAX) m_sc++;
      if (br && m_fc < CMAX) m_fc++;
      if (freeze) begin
        m_wb = EMPTY;
        if (!errored) begin
          if (!waiting) begin
            waiting = 1; waited = 0;
          end else begin
            waited++;
            if (waited == TO) errored = 1;
          end
        end
      end else begin
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = (br || lu || !id.v) ? EMPTY : id;
        waiting = 0;
      end
    end
    #1;
  endtask

  function automatic instr_t rand_instr();
    int k;
    instr_t i;
    k = int'($urandom_range(0, 3));
    i = mk($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 2'b00);
    case (k)
      0: i.src = 2'b01;
      1: begin i.rw = 0; i.mw = 1; end
      2: i.src = 2'b10;
      default: i.rw = 1'($urandom_range(0, 1));
    endcase
    return i;
  endfunction

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      n_vec++;
      chk("stall_IF",     32'(stall_IF),     32'(mon_e.sif));
      chk("stall_ID",     32'(stall_ID),     32'(mon_e.sid));
      chk("stall_EX",     32'(stall_EX),     32'(mon_e.sex));
      chk("stall_MEM",    32'(stall_MEM),    32'(mon_e.smem));
      chk("flush_ID",     32'(flush_ID),     32'(mon_e.fid));
      chk("flush_EX",     32'(flush_EX),     32'(mon_e.fex));
      chk("bubble_WB",    32'(bubble_WB),    32'(mon_e.bwb));
      chk("ForwardAE",    32'(ForwardAE),    32'(mon_e.fa));
      chk("ForwardBE",    32'(ForwardBE),    32'(mon_e.fb));
      chk("mem_timeout",  32'(mem_timeout),  32'(mon_e.tmo));
      chk("stall_cycles", 32'(stall_cycles), 32'(mon_e.sc));
      chk("flush_count",  32'(flush_count),  32'(mon_e.fc));
    end
  end

  instr_t NOP, LW5, ADD6, ADD3, SUB4, SW;

  initial begin
    int dry;
    bit r, pc, mr;
    instr_t id;
    EMPTY = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    NOP  = EMPTY;
    LW5  = mk(1, 5, 1, 0, 1, 0, 1, 0, 2'b01);
    ADD6 = mk(1, 6, 5, 2, 1, 1, 1, 0, 2'b00);
    ADD3 = mk(1, 3, 1, 2, 1, 1, 1, 0, 2'b00);
    SUB4 = mk(1, 4, 3, 1, 1, 1, 1, 0, 2'b00);
    SW   = mk(1, 0, 1, 2, 1, 1, 0, 1, 2'b00);
    model_clear();
    prev_id = EMPTY; prev_pc = 0; last_sid = 0; last_freeze = 0;

    reset = 1; id_valid = 0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_RegWrite = 0; id_MemWrite = 0;
    id_ResultSrc = '0; ex_PCSrc = 0; mem_ready = 1;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    step(1, NOP, 0, 1); step(0, NOP, 0, 1);
    // load-use: lw x5 then add x6,x5,x2
    step(0, LW5, 0, 1); step(0, ADD6, 0, 1); step(0, ADD6, 0, 1);
    step(0, NOP, 0, 1); step(0, NOP, 0, 1);
    // back-to-back ALU
    step(0, ADD3, 0, 1); step(0, SUB4, 0, 1); step(0, NOP, 0, 1); step(0, NOP, 0, 1);
    // branch flush
    step(1, NOP, 0, 1); step(0, ADD3, 1, 1);
    chk("flush_count_after_branch", 32'(flush_count), 32'd1);
    step(0, NOP, 0, 1);
    // memory wait of three cycles
    step(1, NOP, 0, 1); step(0, SW, 0, 1); step(0, NOP, 0, 1);
    step(0, NOP, 0, 0); step(0, NOP, 0, 0); step(0, NOP, 0, 0); step(0, NOP, 0, 1);
    chk("stall_cycles_after_wait", 32'(stall_cycles), 32'd3);
    step(0, NOP, 0, 1);
    // timeout then reset
    step(1, NOP, 0, 1); step(0, SW, 0, 1); step(0, NOP, 0, 1);
    for (int i = 0; i < 7; i++) step(0, NOP, 0, 0);
    chk("mem_timeout_set", 32'(mem_timeout), 32'd1);
    step(1, NOP, 0, 0);
    chk("mem_timeout_cleared", 32'(mem_timeout), 32'd0);
    chk("stall_cycles_cleared", 32'(stall_cycles), 32'd0);
    step(0, NOP, 0, 1);
    // load-use and branch together
    step(1, NOP, 0, 1); step(0, LW5, 0, 1); step(0, ADD6, 1, 1); step(0, NOP, 0, 1);

    // randomized traffic
    dry = 0;
    for (int k = 0; k < 3000; k++) begin
      r  = errored ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
      id = last_sid ? prev_id : rand_instr();
      pc = last_freeze ? prev_pc : ($urandom_range(0, 7) == 0);
      if (dry > 0) begin
        mr = 0; dry--;
      end else begin
        mr = $urandom_range(0, 9) != 0;
        if (!mr && $urandom_range(0, 5) == 0) dry = int'($urandom_range(3, 8));
      end
      step(r, id, pc, mr);
    end

    for (int w = 0; w < 4 && sbq.size() != 0; w++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
